// File: rtl/ex_mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle execute sequencer: FSM states,
// stall vector patterns ({wb, mem, ex, id, if, pc}) and stop flags.
package ex_mc_ctrl_pkg;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam logic [5:0] StallNone = 6'b000000;
    localparam logic [5:0] StallId   = 6'b000111;
    localparam logic [5:0] StallEx   = 6'b001111;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // An execute-stage request must freeze ex as well, so it outranks load-use.
    function automatic logic [5:0] stall_sel(input logic req_ex, input logic req_id);
        if (req_ex == Stop)
            return StallEx;
        else if (req_id == Stop)
            return StallId;
        else
            return StallNone;
    endfunction

endpackage

// File: rtl/ex_mc_ctrl.sv
// Sequencer for iterative execute-stage ops; also the single source of
// pipeline stall control (merges the decode load-use request).
module ex_mc_ctrl
    import ex_mc_ctrl_pkg::*;
#(
    parameter int CNT_W   = 6,
    parameter int STALL_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   cycles_i,
    input  logic               annul_i,
    input  logic               stallreq_id_i,
    output logic               load_o,
    output logic               step_o,
    output logic               done_o,
    output logic               busy_o,
    output logic [CNT_W-1:0]   count_o,
    output logic [STALL_W-1:0] stall_o
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_accept;
    logic             w_run;
    logic             w_stallreq_ex;

    assign w_accept      = (r_state == S_IDLE) && start_i && !annul_i;
    assign w_run         = (r_state == S_RUN);
    assign w_stallreq_ex = (w_accept || w_run) ? Stop : NoStop;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                    w_count_nxt = (cycles_i == '0) ? CNT_W'(1) : cycles_i;
                end
            end
            S_RUN: begin
                if (annul_i) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end else if (r_count == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count - CNT_W'(1);
                end
            end
            // start_i here is still the finished instruction; never retrigger.
            S_DONE: w_state_nxt = S_IDLE;
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Input-driven outputs are gated so everything reads 0 while rst is held.
    assign load_o  = !rst && w_accept;
    assign step_o  = !rst && w_run;
    assign done_o  = !rst && (r_state == S_DONE);
    assign busy_o  = !rst && (w_stallreq_ex == Stop);
    assign count_o = r_count;
    assign stall_o = rst ? '0 : STALL_W'(stall_sel(w_stallreq_ex, stallreq_id_i));

endmodule

// File: tb/tb_ex_mc_ctrl.sv
// Self-checking bench for ex_mc_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a timeline model of each operation.
module tb_ex_mc_ctrl;

    localparam int CNT_W   = 6;
    localparam int STALL_W = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_i;
    logic [CNT_W-1:0]   cycles_i;
    logic               annul_i;
    logic               stallreq_id_i;
    logic               load_o;
    logic               step_o;
    logic               done_o;
    logic               busy_o;
    logic [CNT_W-1:0]   count_o;
    logic [STALL_W-1:0] stall_o;

    int checks   = 0;
    int failures = 0;

    // Model: an op accepted at relative cycle 0 runs in cycles 1..n, done in n+1.
    bit m_active = 1'b0;
    int m_t      = 0;
    int m_n      = 0;

    ex_mc_ctrl #(.CNT_W(CNT_W), .STALL_W(STALL_W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .cycles_i(cycles_i),
        .annul_i(annul_i), .stallreq_id_i(stallreq_id_i), .load_o(load_o),
        .step_o(step_o), .done_o(done_o), .busy_o(busy_o), .count_o(count_o),
        .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] observed();
        return {load_o, step_o, done_o, busy_o, count_o, stall_o};
    endfunction

    function automatic logic [15:0] expect_now();
        logic       ld  = 1'b0;
        logic       st  = 1'b0;
        logic       dn  = 1'b0;
        logic       bz  = 1'b0;
        logic       ex  = 1'b0;
        logic [5:0] cnt = 6'd0;
        logic [5:0] stl = 6'd0;
        if (!rst) begin
            if (!m_active) begin
                if (start_i && !annul_i) begin
                    ld = 1'b1; bz = 1'b1; ex = 1'b1;
                end
            end else if (m_t <= m_n) begin
                st = 1'b1; bz = 1'b1; ex = 1'b1;
                cnt = 6'(m_n - m_t + 1);
            end else begin
                dn = 1'b1;
            end
            stl = ex ? 6'b001111 : (stallreq_id_i ? 6'b000111 : 6'b000000);
        end
        return {ld, st, dn, bz, cnt, stl};
    endfunction

    task automatic apply(input bit r, input bit s, input int cyc, input bit a, input bit id);
        rst           = r;
        start_i       = s;
        cycles_i      = CNT_W'(cyc);
        annul_i       = a;
        stallreq_id_i = id;
        #4;
    endtask

    task automatic tick();
        if (rst) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (start_i && !annul_i) begin
                m_active = 1'b1;
                m_t      = 1;
                m_n      = (cycles_i == '0) ? 1 : int'(cycles_i);
            end
        end else if (m_t <= m_n) begin
            if (annul_i) m_active = 1'b0;
            else         m_t++;
        end else begin
            m_active = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, 5, 1'b0, 1'b1);
            checks++;
            if (observed() !== 16'h0000) begin
                failures++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", i, observed(), 16'h0000);
            end
            tick();
        end
        apply(1'b0, 1'b0, 0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_basic();
        int dones = 0;
        for (int i = 0; i <= 6; i++) begin
            apply(1'b0, i <= 5, 4, 1'b0, 1'b0);
            checks++;
            if (observed() !== expect_now()) begin
                failures++;
                $display("FAIL basic cyc=%0d got=%h exp=%h", i, observed(), expect_now());
            end
            if (i >= 1 && i <= 4) begin
                checks++;
                if (count_o !== CNT_W'(5 - i)) begin
                    failures++;
                    $display("FAIL basic_count cyc=%0d got=%0d exp=%0d", i, count_o, 5 - i);
                end
            end
            if (done_o) dones++;
            tick();
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL basic_dones got=%0d exp=1", dones);
        end
    endtask

    task automatic test_zero_and_max();
        for (int i = 0; i <= 3; i++) begin
            apply(1'b0, i <= 2, 0, 1'b0, 1'b0);
            checks++;
            if (observed() !== expect_now()) begin
                failures++;
                $display("FAIL zero cyc=%0d got=%h exp=%h", i, observed(), expect_now());
            end
            tick();
        end
        for (int i = 0; i <= 65; i++) begin
            apply(1'b0, i <= 64, 63, 1'b0, 1'b0);
            checks++;
            if (observed() !== expect_now()) begin
                failures++;
                $display("FAIL max cyc=%0d got=%h exp=%h", i, observed(), expect_now());
            end
            if (i == 64) begin
                checks++;
                if (done_o !== 1'b1) begin
                    failures++;
                    $display("FAIL max_done got=%b exp=1", done_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_annul();
        int dones = 0;
        for (int i = 0; i <= 12; i++) begin
            apply(1'b0, i <= 2, 8, i == 2, 1'b0);
            checks++;
            if (observed() !== expect_now()) begin
                failures++;
                $display("FAIL annul cyc=%0d got=%h exp=%h", i, observed(), expect_now());
            end
            if (done_o) dones++;
            tick();
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL annul_dones got=%0d exp=0", dones);
        end
    endtask

    task automatic test_back_to_back();
        int loads = 0;
        int dones = 0;
        for (int i = 0; i <= 4; i++) begin
            apply(1'b0, i <= 3, 2, 1'b0, 1'b0);
            checks++;
            if (observed() !== expect_now()) begin
                failures++;
                $display("FAIL hold cyc=%0d got=%h exp=%h", i, observed(), expect_now());
            end
            if (load_o) loads++;
            if (done_o) dones++;
            tick();
        end
        for (int i = 0; i <= 8; i++) begin
            apply(1'b0, i <= 7, 2, 1'b0, 1'b0);
            checks++;
            if (observed() !== expect_now()) begin
                failures++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", i, observed(), expect_now());
            end
            if (load_o) loads++;
            if (done_o) dones++;
            tick();
        end
        checks++;
        if (loads != 3 || dones != 3) begin
            failures++;
            $display("FAIL b2b_counts loads=%0d dones=%0d exp=3/3", loads, dones);
        end
    endtask

    task automatic test_stall_id();
        apply(1'b0, 1'b0, 0, 1'b0, 1'b1);
        checks++;
        if (stall_o !== 6'b000111) begin
            failures++;
            $display("FAIL stall_id_alone got=%b exp=000111", stall_o);
        end
        tick();
        for (int i = 0; i <= 3; i++) begin
            apply(1'b0, i <= 2, 1, 1'b0, 1'b1);
            checks++;
            if (observed() !== expect_now()) begin
                failures++;
                $display("FAIL stall_id cyc=%0d got=%h exp=%h", i, observed(), expect_now());
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_run();
        int dones = 0;
        for (int i = 0; i <= 20; i++) begin
            apply(i == 4 || i == 5, i <= 5, 10, 1'b0, 1'b0);
            checks++;
            if (observed() !== expect_now()) begin
                failures++;
                $display("FAIL rst_mid cyc=%0d got=%h exp=%h", i, observed(), expect_now());
            end
            if (i == 4) begin
                checks++;
                if (observed() !== 16'h0000) begin
                    failures++;
                    $display("FAIL rst_mid_zero got=%h exp=0000", observed());
                end
            end
            if (i > 5 && done_o) dones++;
            tick();
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL rst_mid_dones got=%0d exp=0", dones);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int cyc;
            cyc = ($urandom_range(0, 15) == 0) ? 63 : int'($urandom_range(0, 6));
            apply($urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0, cyc,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0);
            checks++;
            if (observed() !== expect_now()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, observed(), expect_now());
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; cycles_i = '0; annul_i = 1'b0; stallreq_id_i = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_zero_and_max();
        test_annul();
        test_back_to_back();
        test_stall_id();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mc_ctrl.md
Name: ex_mc_ctrl

Overview:
Sequencer for multi-cycle execute-stage operations, such as iterative shift, multiply-accumulate or divide.
- Accepts a start request from the execute stage.
- Drives the step/load enables of a shared iterative unit for a programmed number of cycles.
- Produces the pipeline stall vector consumed by pc_reg and the stage registers.
- Also merges the decode-stage load-use stall request, so it is the single source of pipeline stall control.

Parameters:
CNT_W, 6, width of the iteration counter; max iterations = 2^CNT_W - 1.
STALL_W, 6, stall vector width; bit order {wb, mem, ex, id, if, pc}, bit0 = pc.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high (RstEnable = 1'b1)
start_i  input  1  execute stage holds a multi-cycle op; stays high while the op sits in ex
cycles_i  input  CNT_W  iteration count for this op; 0 is treated as 1
annul_i  input  1  flush; cancels the in-flight op, no done pulse
stallreq_id_i  input  1  decode-stage stall request (load-use)
load_o  output  1  shared unit latches operands (accept cycle)
step_o  output  1  shared unit performs one iteration
done_o  output  1  one-cycle pulse; unit result valid, ex writes it back
busy_o  output  1  op in progress (RUN or accept cycle)
count_o  output  CNT_W  remaining iterations
stall_o  output  STALL_W  pipeline stall vector

Behaviour:
- States: IDLE, RUN, DONE. State register and counter are reset asynchronously by rst to IDLE and count=0.
- During reset, all outputs are 0: load_o, step_o, done_o, busy_o, count_o, stall_o.

IDLE:
- Accept condition: start_i=1 and annul_i=0.
- On accept: load_o=1 (combinational, same cycle).
- Next state RUN. count loads max(cycles_i,1).

RUN:
- step_o=1 every cycle.
- count decrements each cycle.
- When count==1: next state DONE, count becomes 0.

DONE:
- done_o=1 for exactly one cycle.
- Next state IDLE unconditionally.
- start_i in DONE is ignored. It is the same instruction still held in ex, so it must not retrigger.

Latency:
- An op with N iterations occupies ex for N+2 cycles: accept, N×RUN, DONE.
- done_o is asserted in cycle N+1 after the accept cycle.

Stall rules (all combinational from state/inputs):
- stallreq_ex = (IDLE & start_i & ~annul_i) | RUN.
- busy_o = stallreq_ex.
- Priority: stallreq_ex gives stall_o=6'b001111 (pc, if, id, ex held). Otherwise stallreq_id_i gives 6'b000111. Otherwise 6'b000000.
- In DONE, stall_o from ex is 0, so the instruction advances in the same cycle as done_o.

Boundary conditions:
- annul_i in RUN: next state IDLE, count=0, no done_o; step_o still 1 in that cycle (harmless).
- annul_i in DONE: done_o is still asserted, but ex discards the result. The controller takes no special action.
- annul_i together with start_i in IDLE: no accept.
- cycles_i is sampled only at accept; later changes have no effect.
- cycles_i = 2^CNT_W-1 must count fully without wrap.
- Simultaneous stallreq_id_i and an ex request: the ex pattern wins.
- rst asserted mid-RUN: immediately IDLE, all outputs 0, no done_o after release.

Decomposition:
- Shared defines header gets:
  - state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - stall vector patterns (StallNone, StallId, StallEx);
  - Stop/NoStop constants.
- No sub-module. The counter and FSM are small, and the stall encoder stays inline.

Test Plan:
1. Reset mid-RUN: start with cycles_i=10, assert rst at RUN cycle 4 → all outputs 0 immediately, state IDLE, no done_o after release.
2. start_i with cycles_i=4 → load_o in cycle 0; step_o in cycles 1-4; count_o 4,3,2,1; done_o in cycle 5; stall_o=001111 in cycles 0-4 and 000000 in cycle 5.
3. cycles_i=0 → behaves as 1: load, one step, done in cycle 2. cycles_i=63 → 63 steps, done in cycle 64, no wrap.
4. annul_i in RUN cycle 2 of an 8-iteration op → IDLE next cycle, no done_o, stall_o=0 from the next cycle.
5. start_i held high through DONE and then low → exactly one accept and one done_o. start_i high again in the cycle after DONE → a new accept.
6. stallreq_id_i=1 alone → stall_o=000111. stallreq_id_i=1 during RUN → stall_o=001111. stallreq_id_i=1 in DONE → stall_o=000111.
